// File: rtl/adder_seq_pkg.sv
// Shared sizing and FSM state type for the slice-serial adder.
package adder_seq_pkg;

    localparam int unsigned SLICE_W    = 3;
    localparam int unsigned NUM_SLICES = 4;
    localparam int unsigned WIDTH      = SLICE_W * NUM_SLICES;
    // Guard keeps the index at least one bit wide if NUM_SLICES is ever 1.
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

endpackage

// File: rtl/adder_sequencer_if.sv
// Start/done request bus between a requester and the adder sequencer.
interface adder_sequencer_if;
    import adder_seq_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );

endinterface

// File: rtl/adder_sequencer_ripple_carry.sv
// Purely combinational W-bit ripple-carry slice adder.
module ripple_carry #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    logic [W:0] carry;

    // Bit-serial carry ripple from LSB to MSB.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = c_in;
        for (int i = 0; i < int'(W); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[W];

endmodule

// File: rtl/adder_sequencer.sv
// Wide adder that reuses one SLICE_W-bit slice adder, one slice per clock, LSB first.
module adder_sequencer
    import adder_seq_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    adder_sequencer_if.slave  bus
);

    seq_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_a = a_q[idx_q * SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q * SLICE_W +: SLICE_W];

    ripple_carry #(
        .W (SLICE_W)
    ) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // Sequencer FSM: accept in idle/done, one slice per RUN cycle, done pulse after last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.c_in;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    sum_q[idx_q * SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q                           <= slice_cout;
                    if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
                        c_out_q <= slice_cout;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status decoded from registered state only, so glitch-free.
    assign bus.busy  = (state_q == StRun);
    assign bus.done  = (state_q == StDone);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Randomised self-checking bench for adder_sequencer against an arithmetic model.
module tb_adder_sequencer;
    import adder_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic model_cout;  // c_out the DUT should be holding between final slices

    adder_sequencer_if bus ();

    adder_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, leaving us 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after the accepting edge; returns cycles until done is seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) begin
                busy_n++;
                check("cout_hold", 32'(bus.c_out), 32'(model_cout));
            end
            step();
            lat++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input string tag);
        logic [WIDTH:0] exp;
        int lat;
        int busy_n;
        exp        = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
        bus.a      = a;
        bus.b      = b;
        bus.c_in   = cin;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        // Scramble inputs after acceptance; the running operation must not see them.
        bus.a      = WIDTH'($urandom);
        bus.b      = WIDTH'($urandom);
        bus.c_in   = 1'($urandom);
        wait_done(lat, busy_n);
        check({tag, "_lat"}, 32'(lat), 32'(NUM_SLICES + 1));
        check({tag, "_busy"}, 32'(busy_n), 32'(NUM_SLICES));
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(bus.c_out), 32'(exp[WIDTH]));
        model_cout = exp[WIDTH];
        step();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
    endtask

    initial begin
        int lat;
        int busy_n;
        int dones;
        n_tests    = 0;
        n_fail     = 0;
        model_cout = 1'b0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.c_in   = 1'b0;
        rst_n      = 1'b0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.c_out), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed cases
        run_op(12'h000, 12'h000, 1'b0, "zero");
        run_op(12'h7FF, 12'h001, 1'b0, "chain1");
        run_op(12'hFFF, 12'hFFF, 1'b1, "chain2");
        run_op(12'h2B5, 12'h14A, 1'b1, "mixed");

        // Start while busy is ignored
        bus.a = 12'h001; bus.b = 12'h001; bus.c_in = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.a = 12'hFFF; bus.b = 12'hFFF; bus.c_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                dones++;
                check("busy_ign_sum", 32'(bus.sum), 32'h002);
                check("busy_ign_cout", 32'(bus.c_out), 32'd0);
            end
            step();
        end
        check("busy_ign_ndone", 32'(dones), 32'd1);
        model_cout = 1'b0;

        // Back-to-back: start asserted during the DONE cycle
        bus.a = 12'h001; bus.b = 12'h001; bus.c_in = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < NUM_SLICES; i++) step();
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_sum1", 32'(bus.sum), 32'h002);
        bus.a = 12'h800; bus.b = 12'h800; bus.c_in = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, busy_n);
        check("b2b_lat", 32'(lat), 32'(NUM_SLICES + 1));
        check("b2b_sum2", 32'(bus.sum), 32'h000);
        check("b2b_cout2", 32'(bus.c_out), 32'd1);
        model_cout = 1'b1;
        step();

        // Reset during the second RUN cycle
        bus.a = 12'h555; bus.b = 12'h111; bus.c_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_sum", 32'(bus.sum), 32'd0);
        check("arst_cout", 32'(bus.c_out), 32'd0);
        model_cout = 1'b0;
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done || bus.busy) dones++;
            step();
        end
        check("arst_no_done", 32'(dones), 32'd0);
        run_op(12'h123, 12'h456, 1'b0, "post_rst");

        // Random operands against the arithmetic model
        for (int i = 0; i < 500; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
- Multi-cycle wide adder. Adds two WIDTH-bit operands by time-multiplexing one SLICE_W-bit ripple-carry slice adder, one slice per clock, LSB slice first.
- A registered carry links consecutive slices.
- Sits between a simple start/done requester (lab top-level or test controller) and the shared slice adder. Trades latency for area.

Parameters:
- SLICE_W, 3, width of the slice adder in bits.
- NUM_SLICES, 4, number of slices per operation.
- WIDTH, SLICE_W*NUM_SLICES (12), operand and sum width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse. Sampled only in IDLE or DONE.
- a  in  WIDTH  operand A. Sampled on the accepted start edge.
- b  in  WIDTH  operand B. Sampled on the accepted start edge.
- c_in  in  1  carry into the LSB slice. Sampled on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse: result valid.
- sum  out  WIDTH  result register.
- c_out  out  1  carry out of the MSB slice.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy=0, done=0, sum=0, c_out=0. Slice index=0, carry register=0, operand registers=0.
- States:
  - IDLE: start=1 -> latch a, b into operand registers; carry_reg<=c_in; idx<=0; go to RUN. start=0 -> stay in IDLE.
  - RUN: each cycle the slice adder sees a_reg[idx], b_reg[idx], carry_reg.
    - On the clock edge: sum[idx*SLICE_W +: SLICE_W] <= slice sum; carry_reg <= slice cout.
    - idx<NUM_SLICES-1 -> idx<=idx+1, stay in RUN.
    - idx==NUM_SLICES-1 -> c_out<=slice cout, go to DONE.
  - DONE: done=1 for exactly this one cycle.
    - start=1 -> accepted as in IDLE (back-to-back), go to RUN.
    - start=0 -> go to IDLE.
- Latency: start accepted at edge k. done is high in the cycle after edge k+NUM_SLICES, i.e. NUM_SLICES+1 cycles from start to done. Throughput: one result per NUM_SLICES+1 cycles.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state only, so they are glitch-free.
- Slice adder is purely combinational; all results are captured in registers.
- Widths: all slices are exactly SLICE_W bits. Overflow out of the MSB appears only on c_out; no saturation.
- sum is overwritten slice by slice during RUN. It is valid only when done=1, and remains valid afterwards in IDLE until the next accepted start.
- c_out is updated only at the final slice edge. It holds its value in IDLE and through the next RUN until that operation's final slice.
- start while busy=1 is ignored: no queuing, and operand registers are unchanged.
- Input changes on a, b, c_in after acceptance have no effect on the operation in progress.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse for the aborted operation.
- Reset deassertion is synchronised by the integrator. The block itself requires no start in the first cycle after rst_n rises.

Decomposition:
- Package adder_seq_pkg: SLICE_W, NUM_SLICES and WIDTH localparams, plus the state enum (IDLE, RUN, DONE) as a 2-bit typedef.
- Sub-module: one instance of the team's existing ripple_carry slice adder, ports a, b, c_in, sum, c_out. Its width must equal SLICE_W.
- Index counter width = $clog2(NUM_SLICES).

Test Plan:
- Zero add: start with a=0x000, b=0x000, c_in=0 -> done exactly 5 cycles after start; sum=0x000, c_out=0; busy high for 4 cycles.
- Carry chain through all slices: a=0x7FF, b=0x001, c_in=0 -> sum=0x800, c_out=0. Then a=0xFFF, b=0xFFF, c_in=1 -> sum=0xFFF, c_out=1.
- Mixed values: a=0x2B5, b=0x14A, c_in=1 -> sum=0x400, c_out=0. Compare against a reference model over 500 random operand/c_in triples.
- Start during busy: start a=0x001, b=0x001; pulse start again with a=0xFFF, b=0xFFF two cycles later -> single done, sum=0x002; second request ignored.
- Back-to-back: start held high through the DONE cycle with new a=0x800, b=0x800 -> first done, sum=0x002; second done 5 cycles later, sum=0x000, c_out=1.
- Reset mid-operation: assert rst_n=0 asynchronously in the 2nd RUN cycle -> busy=0, done=0, sum=0x000, c_out=0 immediately; no done pulse afterwards; next start completes normally.
